// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared types and constants for the FIR tap scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  localparam int              FP_W    = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_ISSUE = 3'd1,
    S_MUL_WAIT  = 3'd2,
    S_ADD_ISSUE = 3'd3,
    S_ADD_WAIT  = 3'd4,
    S_NEXT      = 3'd5,
    S_DONE      = 3'd6
  } fir_sched_state_t;

  // Only the exact +0 encoding counts as zero; -0 and denormals still multiply.
  function automatic logic is_pos_zero(input logic [FP_W-1:0] v);
    return v == FP_ZERO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_coef_bank.sv
// ============================================================================
// Module      : fir_coef_bank
// Description : TAPS x 32 coefficient register file, writes only while idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS = 8,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idle_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [FP_W-1:0] data_i,
  input  logic [AW-1:0]   rd_idx_i,
  output logic [FP_W-1:0] rd_data_o
);

  logic [FP_W-1:0] mem_q [TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        mem_q[i] <= FP_ZERO;
      end
    end else if (idle_i && we_i) begin
      mem_q[addr_i] <= data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/fir_tap_scheduler.sv
// ============================================================================
// Module      : fir_tap_scheduler
// Description : Time-multiplexes one FP multiplier and one FP adder over the
//               taps of a FIR filter, one output per accepted sample.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_tap_scheduler
  import fir_pkg::*;
#(
  parameter int TAPS    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [FP_W-1:0]         sample_in,
  output logic                    sample_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [FP_W-1:0]         coef_data,
  output logic                    mul_start,
  output logic [FP_W-1:0]         mul_a,
  output logic [FP_W-1:0]         mul_b,
  input  logic                    mul_ready,
  input  logic [FP_W-1:0]         mul_y,
  output logic                    add_start,
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  input  logic                    add_ready,
  input  logic [FP_W-1:0]         add_y,
  output logic                    out_valid,
  output logic [FP_W-1:0]         out_data,
  output logic                    busy,
  output logic                    err
);

  localparam int AW = $clog2(TAPS);
  localparam int CW = $clog2(TIMEOUT + 1);

  fir_sched_state_t state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FP_W-1:0]  acc_q, acc_d;
  logic [FP_W-1:0]  prod_q, prod_d;
  logic             acc_wr_q, acc_wr_d;
  logic [FP_W-1:0]  tap_q [TAPS];

  logic             sample_ready_q, sample_ready_d;
  logic             busy_q, busy_d;
  logic             mul_start_q, mul_start_d;
  logic [FP_W-1:0]  mul_a_q, mul_a_d;
  logic [FP_W-1:0]  mul_b_q, mul_b_d;
  logic             add_start_q, add_start_d;
  logic [FP_W-1:0]  add_a_q, add_a_d;
  logic [FP_W-1:0]  add_b_q, add_b_d;
  logic             out_valid_q, out_valid_d;
  logic [FP_W-1:0]  out_data_q, out_data_d;
  logic             err_q, err_d;

  logic             w_idle;
  logic             w_accept;
  logic [FP_W-1:0]  w_tap;
  logic [FP_W-1:0]  w_coef;

  assign w_idle   = (state_q == S_IDLE);
  // The registered ready is low for one cycle after reset, so it gates acceptance.
  assign w_accept = w_idle && sample_ready_q && sample_valid;
  assign w_tap    = tap_q[k_q];

  fir_coef_bank #(
    .TAPS (TAPS),
    .AW   (AW)
  ) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .idle_i    (w_idle),
    .we_i      (coef_we),
    .addr_i    (coef_addr),
    .data_i    (coef_data),
    .rd_idx_i  (k_q),
    .rd_data_o (w_coef)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        tap_q[i] <= FP_ZERO;
      end
    end else if (w_accept) begin
      tap_q[0] <= sample_in;
      for (int i = 1; i < TAPS; i++) begin
        tap_q[i] <= tap_q[i-1];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    acc_wr_d    = acc_wr_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    add_start_d = 1'b0;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          acc_d    = FP_ZERO;
          acc_wr_d = 1'b0;
          k_d      = '0;
          state_d  = S_MUL_ISSUE;
        end
      end

      S_MUL_ISSUE: begin
        if (is_pos_zero(w_tap) || is_pos_zero(w_coef)) begin
          state_d = S_NEXT;
        end else begin
          mul_a_d     = w_tap;
          mul_b_d     = w_coef;
          mul_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_MUL_WAIT;
        end
      end

      S_MUL_WAIT: begin
        if (mul_ready) begin
          prod_d = mul_y;
          // The first real product seeds the accumulator, saving one add.
          if (!acc_wr_q) begin
            acc_d    = mul_y;
            acc_wr_d = 1'b1;
            state_d  = S_NEXT;
          end else begin
            state_d = S_ADD_ISSUE;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_ADD_ISSUE: begin
        add_a_d     = acc_q;
        add_b_d     = prod_q;
        add_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_ADD_WAIT;
      end

      S_ADD_WAIT: begin
        if (add_ready) begin
          acc_d   = add_y;
          state_d = S_NEXT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_NEXT: begin
        if (k_q == AW'(TAPS - 1)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_MUL_ISSUE;
        end
      end

      S_DONE: begin
        out_data_d  = acc_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    sample_ready_d = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      k_q            <= '0;
      cnt_q          <= '0;
      acc_q          <= FP_ZERO;
      prod_q         <= FP_ZERO;
      acc_wr_q       <= 1'b0;
      sample_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      mul_start_q    <= 1'b0;
      mul_a_q        <= FP_ZERO;
      mul_b_q        <= FP_ZERO;
      add_start_q    <= 1'b0;
      add_a_q        <= FP_ZERO;
      add_b_q        <= FP_ZERO;
      out_valid_q    <= 1'b0;
      out_data_q     <= FP_ZERO;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      prod_q         <= prod_d;
      acc_wr_q       <= acc_wr_d;
      sample_ready_q <= sample_ready_d;
      busy_q         <= busy_d;
      mul_start_q    <= mul_start_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      add_start_q    <= add_start_d;
      add_a_q        <= add_a_d;
      add_b_q        <= add_b_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      err_q          <= err_d;
    end
  end

  assign sample_ready = sample_ready_q;
  assign busy         = busy_q;
  assign mul_start    = mul_start_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign add_start    = add_start_q;
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_scheduler.sv
// ============================================================================
// Module      : tb_fir_tap_scheduler
// Description : Directed scoreboard bench for fir_tap_scheduler (TAPS=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_tap_scheduler;
  import fir_pkg::*;

  localparam int TAPS    = 4;
  localparam int TIMEOUT = 16;
  localparam int AW      = 2;
  localparam int LAT     = 5;

  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] F5  = 32'h40A0_0000;
  localparam logic [31:0] F6  = 32'h40C0_0000;
  localparam logic [31:0] F7  = 32'h40E0_0000;
  localparam logic [31:0] F8  = 32'h4100_0000;
  localparam logic [31:0] F10 = 32'h4120_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            sample_valid;
  logic [31:0]     sample_in;
  logic            sample_ready;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [31:0]     coef_data;
  logic            mul_start;
  logic [31:0]     mul_a, mul_b;
  logic            mul_ready = 1'b0;
  logic [31:0]     mul_y = 32'h0;
  logic            add_start;
  logic [31:0]     add_a, add_b;
  logic            add_ready = 1'b0;
  logic [31:0]     add_y = 32'h0;
  logic            out_valid;
  logic [31:0]     out_data;
  logic            busy;
  logic            err;

  fir_tap_scheduler #(.TAPS(TAPS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_in(sample_in), .sample_ready(sample_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready), .mul_y(mul_y),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_ready(add_ready), .add_y(add_y),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_ev;

  int cyc = 0, n_mul = 0, n_add = 0, mul_cyc = 0;
  bit mul_en = 1'b1;
  int late_req = 0, late_done = 0;
  int m_pend = 0, a_pend = 0;
  logic [31:0] m_res = 32'h0, a_res = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:0] == 31'h0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    real         a;
    int          e;
    logic        s;
    logic [22:0] m;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e), m};
  endfunction

  always @(posedge clk) cyc++;

  // Arithmetic unit models: fixed latency, driven on the falling edge.
  always @(negedge clk) begin
    mul_ready = 1'b0;
    if (late_req != late_done) begin
      mul_ready = 1'b1;
      late_done = late_req;
    end
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0 && mul_en) begin
        mul_ready = 1'b1;
        mul_y     = m_res;
      end
    end
    if (mul_start) begin
      m_pend = LAT;
      m_res  = r2f(f2r(mul_a) * f2r(mul_b));
    end
  end

  always @(negedge clk) begin
    add_ready = 1'b0;
    if (a_pend > 0) begin
      a_pend--;
      if (a_pend == 0) begin
        add_ready = 1'b1;
        add_y     = a_res;
      end
    end
    if (add_start) begin
      a_pend = LAT;
      a_res  = r2f(f2r(add_a) + f2r(add_b));
    end
  end

  // Monitor: counts issue pulses and scores every output/abort event.
  always @(negedge clk) begin
    if (mul_start) begin
      n_mul++;
      mul_cyc = cyc;
    end
    if (add_start) n_add++;
    if (out_valid || err) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got out_valid=%0b err=%0b data=%h, expected no event",
                 out_valid, err, out_data);
      end else begin
        mon_ev = exp_q.pop_front();
        check("event_kind_err", {31'b0, err}, {31'b0, mon_ev.is_err});
        if (!mon_ev.is_err) check("out_data", out_data, mon_ev.data);
      end
    end
  end

  task automatic write_coef(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit cw, input logic [31:0] cd,
                      output int base_m, output int base_a);
    int t;
    t = 0;
    @(negedge clk);
    while (!sample_ready && t < 50) begin @(negedge clk); t++; end
    check("send_ready", {31'b0, sample_ready}, 32'd1);
    base_m = n_mul;
    base_a = n_add;
    sample_valid = 1'b1; sample_in = d;
    coef_we = cw; coef_addr = '0; coef_data = cd;
    @(negedge clk);
    sample_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic wait_evt();
    int t;
    t = 0;
    while (!(out_valid || err) && t < 300) begin @(negedge clk); t++; end
    check("event_seen", {31'b0, (out_valid | err)}, 32'd1);
  endtask

  task automatic run(input logic [31:0] d, input logic [31:0] exp_d,
                     input int exp_m, input int exp_a);
    int bm, ba;
    exp_q.push_back('{1'b0, exp_d});
    send(d, 1'b0, FP_ZERO, bm, ba);
    wait_evt();
    check("mul_start_count", 32'(n_mul - bm), 32'(exp_m));
    check("add_start_count", 32'(n_add - ba), 32'(exp_a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int t, bm, ba;
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sample_ready", {31'b0, sample_ready}, 32'd0);
    check("rst_busy",         {31'b0, busy},         32'd0);
    check("rst_out_valid",    {31'b0, out_valid},    32'd0);
    check("rst_err",          {31'b0, err},          32'd0);
    check("rst_mul_start",    {31'b0, mul_start},    32'd0);
    check("rst_add_start",    {31'b0, add_start},    32'd0);
    check("rst_out_data",     out_data,              FP_ZERO);
    check("rst_mul_a",        mul_a,                 FP_ZERO);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'b0, sample_ready}, 32'd1);

    // Unit coefficients, ramp input; leading empty taps are skipped.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), FP_ONE);
    run(FP_ONE, FP_ONE, 1, 0);
    run(F2,     F3,     2, 1);
    run(F3,     F6,     3, 2);
    run(F4,     F10,    4, 3);

    // Zero coefficient on tap 2 suppresses that multiply.
    write_coef(2'd2, FP_ZERO);
    run(FP_ONE, F7, 3, 2);
    run(FP_ONE, F5, 3, 2);
    run(FP_ONE, F6, 3, 2);
    run(FP_ONE, F3, 3, 2);

    // Multiplier never answers: abort after TIMEOUT cycles, late ready ignored.
    mul_en = 1'b0;
    exp_q.push_back('{1'b1, FP_ZERO});
    send(F5, 1'b0, FP_ZERO, bm, ba);
    wait_evt();
    check("timeout_err",       {31'b0, err},          32'd1);
    check("timeout_no_out",    {31'b0, out_valid},    32'd0);
    check("timeout_distance",  32'(cyc - mul_cyc),    32'(TIMEOUT));
    check("timeout_ready",     {31'b0, sample_ready}, 32'd1);
    check("timeout_mul_count", 32'(n_mul - bm),       32'd1);
    late_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_ready_busy",  {31'b0, busy},         32'd0);
      check("late_ready_ready", {31'b0, sample_ready}, 32'd1);
    end
    mul_en = 1'b1;

    // Line is now [5,1,1,1]; writes and samples while busy must be ignored.
    exp_q.push_back('{1'b0, F8});
    send(F2, 1'b0, FP_ZERO, bm, ba);
    t = 0;
    while (!mul_start && t < 20) begin @(negedge clk); t++; end
    check("busy_mul_started", {31'b0, mul_start},    32'd1);
    check("busy_ready_low",   {31'b0, sample_ready}, 32'd0);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = F2;
    sample_valid = 1'b1; sample_in = F7;
    @(negedge clk);
    check("busy_ready_low2",  {31'b0, sample_ready}, 32'd0);
    coef_we = 1'b0; sample_valid = 1'b0;
    wait_evt();
    run(FP_ONE, F4, 3, 2);

    // Reset while the adder is busy: computation discarded, bank cleared.
    send(F3, 1'b0, FP_ZERO, bm, ba);
    t = 0;
    while (!add_start && t < 100) begin @(negedge clk); t++; end
    check("midop_add_started", {31'b0, add_start}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midop_busy",      {31'b0, busy},         32'd0);
    check("midop_out_valid", {31'b0, out_valid},    32'd0);
    check("midop_err",       {31'b0, err},          32'd0);
    check("midop_ready",     {31'b0, sample_ready}, 32'd0);
    run(FP_ONE, FP_ZERO, 0, 0);

    // Coefficient write and sample in the same idle cycle on an empty line.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{1'b0, F2});
    send(FP_ONE, 1'b1, F2, bm, ba);
    wait_evt();
    check("same_cycle_mul_count", 32'(n_mul - bm), 32'd1);
    check("same_cycle_add_count", 32'(n_add - ba), 32'd0);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_tap_scheduler.md
Name: fir_tap_scheduler

Overview:
Sequences one shared floating-point multiplier and one shared floating-point adder to compute one FIR output per accepted input sample.
- Holds the sample delay line and the coefficient bank.
- Issues one multiply per tap and accumulates the products through the adder.
- Sits between the sample source and the FIR output, and owns both arithmetic units.
- All data is IEEE-754 single precision.

Parameters:
TAPS, 8, number of filter taps (2..64).
TIMEOUT, 64, max cycles to wait for mul_ready/add_ready before aborting.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active high
sample_valid  in  1  new sample offered
sample_in  in  32  sample value
sample_ready  out  1  scheduler idle, sample accepted this cycle if sample_valid
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index
coef_data  in  32  coefficient value
mul_start  out  1  one-cycle start pulse to multiplier
mul_a  out  32  multiplier operand A (sample tap)
mul_b  out  32  multiplier operand B (coefficient)
mul_ready  in  1  one-cycle result-valid pulse from multiplier
mul_y  in  32  multiplier result
add_start  out  1  one-cycle start pulse to adder
add_a  out  32  adder operand A (accumulator)
add_b  out  32  adder operand B (product)
add_ready  in  1  one-cycle result-valid pulse from adder
add_y  in  32  adder result
out_valid  out  1  one-cycle pulse, out_data valid
out_data  out  32  filter output
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all outputs 0. Delay line, coefficients, accumulator, tap index k and wait counter are all cleared to 0. State = IDLE.
- Reset mid-operation discards the computation. No out_valid or err is emitted. Late mul_ready/add_ready pulses after reset are ignored.
- All outputs are registered.
- States: IDLE, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, NEXT, DONE.
- IDLE:
  - sample_ready=1.
  - If sample_valid: shift the delay line (tap0 <= sample_in, tap[i] <= tap[i-1]), clear acc and k, go to MUL_ISSUE.
  - Coefficient writes take effect only in IDLE. coef_we in any other state is ignored.
  - If coef_we and sample_valid occur in the same IDLE cycle, both take effect. The new coefficient is used by this sample.
- MUL_ISSUE:
  - If tap[k]==32'h0 or coef[k]==32'h0 (exact +0 only): skip the multiply, product=0, acc unchanged, go to NEXT.
  - Otherwise: mul_a=tap[k], mul_b=coef[k], pulse mul_start, clear the wait counter, go to MUL_WAIT.
- Operand hold: mul_a/mul_b stay stable from MUL_ISSUE until mul_ready. add_a/add_b stay stable from ADD_ISSUE until add_ready.
- MUL_WAIT:
  - On mul_ready: capture mul_y.
  - If acc has not yet been written this sample: acc <= mul_y, go to NEXT.
  - Otherwise: go to ADD_ISSUE.
- ADD_ISSUE: add_a=acc, add_b=product, pulse add_start, clear the wait counter, go to ADD_WAIT.
- ADD_WAIT: on add_ready, acc <= add_y, go to NEXT.
- Timeout:
  - The wait counter increments each cycle in MUL_WAIT/ADD_WAIT.
  - On reaching TIMEOUT without ready: pulse err, go to IDLE, no out_valid.
  - A ready arriving in the same cycle the counter hits TIMEOUT wins (result accepted).
- NEXT: if k==TAPS-1 go to DONE, else k <= k+1 and go to MUL_ISSUE.
- DONE: out_data <= acc, out_valid=1 for one cycle, go to IDLE.
- Latency, no skips: 1 + TAPS*(MUL_ISSUE + mul latency + NEXT) + (TAPS-1)*(ADD_ISSUE + add latency) + DONE.
- An all-zero product set yields out_data=32'h0.
- ready pulses arriving outside the matching WAIT state are ignored.

Decomposition:
- fir_pkg: state enum fir_sched_state_t, FP_W=32, FP_ZERO=32'h0000_0000, FP_ONE=32'h3F80_0000.
- Sub-module fir_coef_bank: TAPS x 32 register file, synchronous write gated by an idle input, combinational read by index, synchronous clear on rst.

Test Plan:
1. TAPS=4, behavioural mul/add models (latency 5). Reset, write coef 0..3 = 0x3F800000, push samples 1.0, 2.0, 3.0, 4.0 -> out_data 0x3F800000, 0x40400000, 0x40C00000, 0x41200000. mul_start counts 1, 2, 3, 4 (zero skip on empty taps). add_start counts 0, 1, 2, 3.
2. coef2=0, others 1.0, push 1.0 x4 -> last output 0x40400000 (3.0). Tap 2 issues no mul_start.
3. Multiplier model never asserts mul_ready, TIMEOUT=16 -> err pulses exactly 16 cycles after mul_start, no out_valid, sample_ready=1 next cycle. A later late mul_ready causes no state change.
4. coef_we asserted in MUL_WAIT with coef_data=0x40000000 -> no effect. Next output matches the old coefficients. sample_valid while busy -> sample_ready=0, delay line unchanged.
5. rst asserted for one cycle in ADD_WAIT -> next cycle busy=0, out_valid=0, err=0. Following sample with all coefs zero (reset) -> out_data=0x00000000 with zero mul_start pulses.
6. coef_we and sample_valid in the same IDLE cycle (coef0=0x40000000, sample 1.0, empty line) -> out_data=0x40000000.
